nn_classifier: RTL
==================

NN_CLASSIFIER -- requirements
Module: nn_classifier

Interface
REQ-001 SHALL have parameter N_CLASSES, default 10: number of output classes (digits 0-9).
REQ-002 SHALL have parameter IMG_DIM, default 14: image is IMG_DIM x IMG_DIM binary pixels.
REQ-003 SHALL have parameter WEIGHT_SET, default 0: 0 = trained weights, 1 = test weights.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port image_data, input, 196: image; row r = image_data[14*r +: 14].
REQ-007 SHALL have port image_ready, input, 1: level from upstream image loader; a rising edge requests a classification.
REQ-008 SHALL have port digit_bcd, output, 4: classified digit, 0-9.
REQ-009 SHALL have port result_valid, output, 1: digit_bcd holds a completed result.
REQ-010 SHALL have port busy, output, 1: high while computing.

Function
REQ-011 SHALL implement a single-layer binary network: score(c) = sum over rows r of popcount(XNOR(image row r, weight row (c,r))).
REQ-012 SHALL have FSM states IDLE, ACCUM and DONE.
REQ-013 SHALL register image_ready every cycle; start = image_ready high AND registered value low.
REQ-014 SHALL, on start in IDLE or DONE, do all of: latch image_data into an internal 196-bit snapshot; clear result_valid; zero class/row counters and accumulator; enter ACCUM.
REQ-015 SHALL, in ACCUM, process exactly one (class, row) pair per cycle: row 0..13 inner, class 0..9 outer; 140 cycles total.
REQ-016 SHALL keep the per-row popcount 4 bits wide (0..14) and the class score 8 bits wide (0..196); no saturation is needed.
REQ-017 SHALL, on row 13 of each class, compare the final score: class 0 always loads best; class c>0 replaces best only if its score is strictly greater. Ties therefore resolve to the lowest index.
REQ-018 SHALL, on the cycle processing (class 9, row 13), load digit_bcd with the best index, set result_valid=1 and enter DONE. result_valid is visible 140 edges after the start-capture edge.
REQ-019 SHALL hold digit_bcd and result_valid in DONE until the next start.
REQ-020 SHALL drive busy = 1 exactly in ACCUM.
REQ-021 SHALL ignore start while in ACCUM; the edge register still updates, so no start is deferred.
REQ-022 SHALL ignore image_ready falling and image_data changes during ACCUM, because computation uses the snapshot.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-ACCUM, immediately force: state IDLE, digit_bcd=0, result_valid=0, busy=0, counters/accumulator/best=0, edge register=0.
REQ-024 SHALL start a classification on the first clock after reset release if image_ready is already high at that clock.

Structure
REQ-025 SHALL place N_CLASSES, IMG_DIM, the score/popcount widths, the FSM state encoding and both weight tables in shared package nn_pkg.
REQ-026 SHALL use one sub-module, nn_weight_rom: combinational; inputs class_idx[3:0], row_idx[3:0]; output weight_row[13:0]; returns 0 for class_idx>9 or row_idx>13.
REQ-027 SHALL define the test weight set (WEIGHT_SET=1) as: weight row (c,r) = 14'h3FFF if r==c, else 0.

Verification (WEIGHT_SET=1)
REQ-028 SHALL cover: image all zeros, image_ready rising -> all scores 182 (tie), digit_bcd=0, result_valid high exactly 140 cycles after capture, busy high for exactly 140 cycles.
REQ-029 SHALL cover: row 3 all ones, rest zero -> class 3 scores 196, others 168, digit_bcd=3.
REQ-030 SHALL cover: rows 5 and 9 all ones, rest zero -> classes 5 and 9 score 182, others 154, digit_bcd=5 (tie goes to the lower index).
REQ-031 SHALL cover: second image_ready pulse and image_data change mid-ACCUM -> both ignored, result matches the first image, no second run follows.
REQ-032 SHALL cover: rst_n asserted at cycle 70 of ACCUM -> outputs 0 immediately; after release, a new rising edge with row 7 ones -> digit_bcd=7.
REQ-033 SHALL cover: image_ready held high across DONE -> no retrigger; lower then raise image_ready -> result_valid drops on the start edge and a new result follows 140 cycles later.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the binary nearest-pattern digit classifier:
// geometry, datapath widths, FSM encoding, weight tables and popcount.
package nn_pkg;

    localparam int N_CLASSES = 10;
    localparam int IMG_DIM   = 14;
    localparam int IMG_BITS  = IMG_DIM * IMG_DIM;
    localparam int POP_W     = 4;   // one row popcount, 0..14
    localparam int SCORE_W   = 8;   // one class score, 0..196
    localparam int IDX_W     = 4;   // class / row counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Trained glyph templates, indexed [class][row]; bit 13 is the leftmost pixel.
    localparam logic [0:N_CLASSES-1][0:IMG_DIM-1][IMG_DIM-1:0] TRAINED_W = {
        {14'h0000, 14'h07E0, 14'h0FF0, 14'h1C38, 14'h1818, 14'h1818, 14'h1818,
         14'h1818, 14'h1818, 14'h1818, 14'h1C38, 14'h0FF0, 14'h07E0, 14'h0000},
        {14'h0000, 14'h0180, 14'h0380, 14'h0780, 14'h0180, 14'h0180, 14'h0180,
         14'h0180, 14'h0180, 14'h0180, 14'h0180, 14'h0180, 14'h07E0, 14'h0000},
        {14'h0000, 14'h07E0, 14'h0C30, 14'h0030, 14'h0030, 14'h0060, 14'h00C0,
         14'h0180, 14'h0300, 14'h0600, 14'h0C00, 14'h0FF0, 14'h0FF0, 14'h0000},
        {14'h0000, 14'h0FE0, 14'h0030, 14'h0030, 14'h0030, 14'h03E0, 14'h03E0,
         14'h0030, 14'h0030, 14'h0030, 14'h0030, 14'h0FE0, 14'h0FC0, 14'h0000},
        {14'h0000, 14'h0060, 14'h00E0, 14'h01E0, 14'h0360, 14'h0660, 14'h0C60,
         14'h1FF8, 14'h1FF8, 14'h0060, 14'h0060, 14'h0060, 14'h0060, 14'h0000},
        {14'h0000, 14'h0FF0, 14'h0C00, 14'h0C00, 14'h0C00, 14'h0FE0, 14'h0030,
         14'h0030, 14'h0030, 14'h0030, 14'h0C30, 14'h07E0, 14'h03C0, 14'h0000},
        {14'h0000, 14'h03E0, 14'h0600, 14'h0C00, 14'h0C00, 14'h0FE0, 14'h0E30,
         14'h0C30, 14'h0C30, 14'h0C30, 14'h0C30, 14'h07E0, 14'h03C0, 14'h0000},
        {14'h0000, 14'h0FF8, 14'h0FF8, 14'h0018, 14'h0030, 14'h0060, 14'h00C0,
         14'h0180, 14'h0180, 14'h0300, 14'h0300, 14'h0300, 14'h0300, 14'h0000},
        {14'h0000, 14'h07E0, 14'h0C30, 14'h0C30, 14'h0C30, 14'h07E0, 14'h07E0,
         14'h0C30, 14'h0C30, 14'h0C30, 14'h0C30, 14'h07E0, 14'h03C0, 14'h0000},
        {14'h0000, 14'h07E0, 14'h0C30, 14'h0C30, 14'h0C30, 14'h0C30, 14'h07F0,
         14'h0030, 14'h0030, 14'h0030, 14'h0060, 14'h07C0, 14'h0780, 14'h0000}
    };

    // Test weight set: class c is an all-ones stripe on row c, zero elsewhere.
    function automatic logic [IMG_DIM-1:0] test_w(input logic [IDX_W-1:0] c,
                                                  input logic [IDX_W-1:0] r);
        return (r == c) ? '1 : '0;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [IMG_DIM-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < IMG_DIM; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/nn_weight_rom.sv
// Combinational weight lookup; out-of-range class/row reads as zero.
module nn_weight_rom
    import nn_pkg::*;
#(
    parameter int WEIGHT_SET = 0
) (
    input  logic [IDX_W-1:0]   class_idx,
    input  logic [IDX_W-1:0]   row_idx,
    output logic [IMG_DIM-1:0] weight_row
);

    // Select the weight row from the chosen table, zero outside the grid
    always_comb begin
        weight_row = '0;
        if (int'(class_idx) < N_CLASSES && int'(row_idx) < IMG_DIM) begin
            if (WEIGHT_SET == 1) weight_row = test_w(class_idx, row_idx);
            else                 weight_row = TRAINED_W[class_idx][row_idx];
        end
    end

endmodule

// File: rtl/nn_classifier.sv
// Single-layer binary network: one (class,row) XNOR-popcount per cycle over a
// latched image snapshot, running argmax with ties kept at the lowest class.
module nn_classifier
    import nn_pkg::*;
#(
    parameter int N_CLASSES  = 10,
    parameter int IMG_DIM    = 14,
    parameter int WEIGHT_SET = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [IMG_DIM*IMG_DIM-1:0]   image_data,
    input  logic                         image_ready,
    output logic [3:0]                   digit_bcd,
    output logic                         result_valid,
    output logic                         busy
);

    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(IMG_DIM - 1);
    localparam logic [IDX_W-1:0] CLS_LAST = IDX_W'(N_CLASSES - 1);

    state_e                       state_q, state_d;
    logic                         ready_q;
    logic [IMG_DIM*IMG_DIM-1:0]   snap_q;
    logic [IDX_W-1:0]             cls_q, row_q, best_idx_q;
    logic [SCORE_W-1:0]           acc_q, best_score_q, score_d;
    logic [3:0]                   digit_q;
    logic                         valid_q;
    logic [IMG_DIM-1:0]           w_row, img_row;
    logic                         start, load, row_last, cls_last, take;

    assign start    = image_ready & ~ready_q;
    assign load     = start && (state_q != S_ACCUM);
    assign row_last = (row_q == ROW_LAST);
    assign cls_last = (cls_q == CLS_LAST);

    nn_weight_rom #(.WEIGHT_SET(WEIGHT_SET)) u_rom (
        .class_idx  (cls_q),
        .row_idx    (row_q),
        .weight_row (w_row)
    );

    assign img_row = snap_q[IMG_DIM*int'(row_q) +: IMG_DIM];
    assign score_d = acc_q + SCORE_W'(popcount(~(img_row ^ w_row)));
    // Class 0 always seeds the best; later classes must strictly beat it
    assign take    = (cls_q == '0) || (score_d > best_score_q);

    // Edge detector on image_ready, updated every cycle in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= image_ready;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: start is only honoured outside ACCUM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ACCUM;
            S_ACCUM: if (row_last && cls_last) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_ACCUM;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_ACCUM);
    end

    // Snapshot, counters, accumulator and running argmax
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q       <= '0;
            cls_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            digit_q      <= '0;
            valid_q      <= 1'b0;
        end else if (load) begin
            snap_q       <= image_data;
            valid_q      <= 1'b0;
            cls_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else if (state_q == S_ACCUM) begin
            if (row_last) begin
                acc_q <= '0;
                row_q <= '0;
                cls_q <= cls_q + IDX_W'(1);
                if (take) begin
                    best_idx_q   <= cls_q;
                    best_score_q <= score_d;
                end
                if (cls_last) begin
                    digit_q <= take ? cls_q : best_idx_q;
                    valid_q <= 1'b1;
                end
            end else begin
                acc_q <= score_d;
                row_q <= row_q + IDX_W'(1);
            end
        end
    end

    assign digit_bcd    = digit_q;
    assign result_valid = valid_q;

endmodule
